// File: rtl/array_index_walker.sv
// array_index_walker: walks every index tuple of a 3-D array in declaration order,
// dimension 1 outermost and dimension 3 innermost, one tuple per valid/ready beat.
module array_index_walker #(
    parameter int          L1 = 7,
    parameter int          R1 = 2,
    parameter int          L2 = 2,
    parameter int          R2 = 9,
    parameter int          L3 = 1,
    parameter int          R3 = 4,
    parameter int unsigned IW = 8,
    parameter int unsigned OW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          ready,
    output logic          valid,
    output logic [IW-1:0] idx1,
    output logic [IW-1:0] idx2,
    output logic [IW-1:0] idx3,
    output logic [OW-1:0] offset,
    output logic          last,
    output logic          busy,
    output logic          done
);

    // Walking left to right moves an index down when left >= right, up otherwise.
    localparam logic DOWN1 = (L1 >= R1);
    localparam logic DOWN2 = (L2 >= R2);
    localparam logic DOWN3 = (L3 >= R3);

    localparam logic [IW-1:0] LEFT1  = IW'(L1);
    localparam logic [IW-1:0] LEFT2  = IW'(L2);
    localparam logic [IW-1:0] LEFT3  = IW'(L3);
    localparam logic [IW-1:0] RIGHT1 = IW'(R1);
    localparam logic [IW-1:0] RIGHT2 = IW'(R2);
    localparam logic [IW-1:0] RIGHT3 = IW'(R3);

    // A 1x1x1 array makes the very first beat also the last one.
    localparam logic SINGLE = (L1 == R1) && (L2 == R2) && (L3 == R3);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] nxt1;
    logic [IW-1:0] nxt2;
    logic [IW-1:0] nxt3;
    logic          nxt_last;

    // Next index tuple: innermost steps, carrying outward when an index sits on its right bound.
    always_comb begin
        nxt1 = idx1;
        nxt2 = idx2;
        nxt3 = idx3;
        if (idx3 == RIGHT3) begin
            nxt3 = LEFT3;
            if (idx2 == RIGHT2) begin
                nxt2 = LEFT2;
                nxt1 = DOWN1 ? (idx1 - IW'(1)) : (idx1 + IW'(1));
            end else begin
                nxt2 = DOWN2 ? (idx2 - IW'(1)) : (idx2 + IW'(1));
            end
        end else begin
            nxt3 = DOWN3 ? (idx3 - IW'(1)) : (idx3 + IW'(1));
        end
        nxt_last = (nxt1 == RIGHT1) && (nxt2 == RIGHT2) && (nxt3 == RIGHT3);
    end

    // Walk control and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            last   <= 1'b0;
            idx1   <= LEFT1;
            idx2   <= LEFT2;
            idx3   <= LEFT3;
            offset <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state  <= RUN;
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                        last   <= SINGLE;
                        idx1   <= LEFT1;
                        idx2   <= LEFT2;
                        idx3   <= LEFT3;
                        offset <= '0;
                    end
                end
                RUN: begin
                    if (abort || (ready && last)) begin
                        // Leave the walk; only a completed walk pulses done.
                        state  <= IDLE;
                        valid  <= 1'b0;
                        busy   <= 1'b0;
                        last   <= 1'b0;
                        done   <= !abort;
                        idx1   <= LEFT1;
                        idx2   <= LEFT2;
                        idx3   <= LEFT3;
                        offset <= '0;
                    end else if (ready) begin
                        idx1   <= nxt1;
                        idx2   <= nxt2;
                        idx3   <= nxt3;
                        offset <= offset + OW'(1);
                        last   <= nxt_last;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_index_walker.sv
// Bench for array_index_walker: default 6x8x4 walk plus a small 1x2x1 instance.
module tb_array_index_walker;

    logic       clk;
    logic       rst;
    logic       start, abort, ready;
    logic       valid, last, busy, done;
    logic [7:0] idx1, idx2, idx3, offset;

    logic       start_s, abort_s, ready_s;
    logic       valid_s, last_s, busy_s, done_s;
    logic [7:0] idx1_s, idx2_s, idx3_s, offset_s;

    int errors = 0;
    int checks = 0;

    // Reference shape with the default bounds; only its array queries are used.
    logic [1:4] shape [7:2][2:9];

    typedef struct {
        logic [7:0] i1;
        logic [7:0] i2;
        logic [7:0] i3;
        logic [7:0] off;
        logic       lst;
    } exp_t;

    typedef struct {
        int         off;
        logic [7:0] i1;
        logic [7:0] i2;
        logic [7:0] i3;
        logic       lst;
    } vec_t;

    exp_t sb [$];
    exp_t cap [0:191];
    bit   capture;
    int   beats;

    array_index_walker dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
        .valid(valid), .idx1(idx1), .idx2(idx2), .idx3(idx3), .offset(offset),
        .last(last), .busy(busy), .done(done)
    );

    array_index_walker #(.L1(3), .R1(3), .L2(0), .R2(1), .L3(5), .R3(5)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .ready(ready_s),
        .valid(valid_s), .idx1(idx1_s), .idx2(idx2_s), .idx3(idx3_s), .offset(offset_s),
        .last(last_s), .busy(busy_s), .done(done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected walk from nested loops over the reference array, left to right.
    task automatic push_walk();
        exp_t e;
        int   n;
        n = 0;
        for (int a = 0; a < $size(shape, 1); a++)
            for (int b = 0; b < $size(shape, 2); b++)
                for (int c = 0; c < $size(shape, 3); c++) begin
                    e.i1  = 8'($left(shape, 1) - a * $increment(shape, 1));
                    e.i2  = 8'($left(shape, 2) - b * $increment(shape, 2));
                    e.i3  = 8'($left(shape, 3) - c * $increment(shape, 3));
                    e.off = 8'(n);
                    e.lst = (a == $size(shape, 1) - 1) && (b == $size(shape, 2) - 1) &&
                            (c == $size(shape, 3) - 1);
                    sb.push_back(e);
                    n++;
                end
    endtask

    // Compare the beat being accepted at the coming edge against the scoreboard head.
    task automatic check_beat();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(offset), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("idx1", 32'(idx1), 32'(e.i1));
            chk("idx2", 32'(idx2), 32'(e.i2));
            chk("idx3", 32'(idx3), 32'(e.i3));
            chk("offset", 32'(offset), 32'(e.off));
            chk("last", 32'(last), 32'(e.lst));
            if (capture) begin
                cap[offset].i1  = idx1;
                cap[offset].i2  = idx2;
                cap[offset].i3  = idx3;
                cap[offset].off = offset;
                cap[offset].lst = last;
            end
            beats++;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_last"}, 32'(last), 0);
        chk({tag, "_idx1"}, 32'(idx1), 7);
        chk({tag, "_idx2"}, 32'(idx2), 2);
        chk({tag, "_idx3"}, 32'(idx3), 1);
        chk({tag, "_offset"}, 32'(offset), 0);
    endtask

    // One walk on the default instance with optional stall, abort, reset and random ready.
    task automatic run_walk(input int stall_at, input int abort_at, input int rst_at, input bit rnd);
        bit         stalled;
        bit         was_last;
        bit         finished;
        logic [7:0] s1, s2, s3, so;
        stalled  = 0;
        finished = 0;
        beats    = 0;
        push_walk();
        start = 1'b1;
        ready = 1'b1;
        cycle();
        start = 1'b0;
        chk("first_valid", 32'(valid), 1);
        chk("first_busy", 32'(busy), 1);
        for (int n = 0; n < 2000; n++) begin
            if (!valid) begin
                chk("valid_in_run", 32'(valid), 1);
                break;
            end
            if (offset == 8'(stall_at) && !stalled) begin
                stalled = 1;
                s1 = idx1; s2 = idx2; s3 = idx3; so = offset;
                ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    cycle();
                    chk("stall_valid", 32'(valid), 1);
                    chk("stall_offset", 32'(offset), 32'(so));
                    chk("stall_idx", {8'd0, idx1, idx2, idx3}, {8'd0, s1, s2, s3});
                end
            end
            if (offset == 8'(abort_at)) begin
                abort = 1'b1;
                ready = 1'b1;
                cycle();
                abort = 1'b0;
                check_idle("abort");
                chk("abort_done", 32'(done), 0);
                sb.delete();
                return;
            end
            if (offset == 8'(rst_at)) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                check_idle("rst");
                chk("rst_done", 32'(done), 0);
                sb.delete();
                return;
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (n % 7 == 3);
            was_last = last;
            if (ready) check_beat();
            cycle();
            if (ready && was_last) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        ready = 1'b1;
        chk("walk_finished", 32'(finished), 1);
        chk("beat_count", 32'(beats), 192);
        chk("sb_drained", 32'(sb.size()), 0);
        chk("done_pulse", 32'(done), 1);
        check_idle("end");
        cycle();
        chk("done_one_cycle", 32'(done), 0);
        sb.delete();
    endtask

    initial begin
        vec_t vt [5];
        vt[0] = '{off: 0,   i1: 7, i2: 2, i3: 1, lst: 0};
        vt[1] = '{off: 1,   i1: 7, i2: 2, i3: 2, lst: 0};
        vt[2] = '{off: 4,   i1: 7, i2: 3, i3: 1, lst: 0};
        vt[3] = '{off: 32,  i1: 6, i2: 2, i3: 1, lst: 0};
        vt[4] = '{off: 191, i1: 2, i2: 9, i3: 4, lst: 1};

        rst = 1'b1; start = 0; abort = 0; ready = 0;
        start_s = 0; abort_s = 0; ready_s = 0;
        capture = 0;
        cycle();
        cycle();
        rst = 1'b0;
        check_idle("reset");
        chk("reset_done", 32'(done), 0);

        // Full walk with ready held high, then spot beats from the table.
        capture = 1;
        run_walk(-1, -1, -1, 0);
        capture = 0;
        for (int i = 0; i < 5; i++) begin
            chk("tbl_idx1", 32'(cap[vt[i].off].i1), 32'(vt[i].i1));
            chk("tbl_idx2", 32'(cap[vt[i].off].i2), 32'(vt[i].i2));
            chk("tbl_idx3", 32'(cap[vt[i].off].i3), 32'(vt[i].i3));
            chk("tbl_last", 32'(cap[vt[i].off].lst), 32'(vt[i].lst));
        end

        run_walk(37, -1, -1, 0);
        run_walk(-1, 10, -1, 0);
        run_walk(-1, -1, -1, 0);
        run_walk(-1, -1, 100, 0);
        run_walk(-1, -1, -1, 1);

        // abort in IDLE suppresses a same-cycle start.
        abort = 1'b1;
        start = 1'b1;
        cycle();
        abort = 1'b0;
        start = 1'b0;
        chk("idle_abort_valid", 32'(valid), 0);
        chk("idle_abort_busy", 32'(busy), 0);

        // Small instance: two beats, then a restart in the done cycle.
        ready_s = 1'b1;
        start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        chk("s_b0", {valid_s, last_s, 6'd0, idx1_s, idx2_s, idx3_s}, {1'b1, 1'b0, 6'd0, 8'd3, 8'd0, 8'd5});
        chk("s_b0_off", 32'(offset_s), 0);
        cycle();
        chk("s_b1", {valid_s, last_s, 6'd0, idx1_s, idx2_s, idx3_s}, {1'b1, 1'b1, 6'd0, 8'd3, 8'd1, 8'd5});
        chk("s_b1_off", 32'(offset_s), 1);
        cycle();
        chk("s_done", {29'd0, done_s, valid_s, busy_s}, {29'd0, 1'b1, 1'b0, 1'b0});
        start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        chk("s_restart", {valid_s, last_s, done_s, 5'd0, idx1_s, idx2_s, idx3_s}, {1'b1, 1'b0, 1'b0, 5'd0, 8'd3, 8'd0, 8'd5});
        cycle();
        chk("s_r_b1", {valid_s, last_s, 6'd0, idx1_s, idx2_s, idx3_s}, {1'b1, 1'b1, 6'd0, 8'd3, 8'd1, 8'd5});
        cycle();
        chk("s_r_done", 32'(done_s), 1);
        cycle();
        chk("s_r_done_clr", 32'(done_s), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
